// File: rtl/dpr_copy_engine_if.sv
// RAM-side bus of the copy engine: port A is the read port, port B the write port
// of a dual-port RAM with a one-cycle registered read.
interface dpr_copy_engine_if #(
  parameter int ADDR_SIZE = 8,
  parameter int DATA_SIZE = 8
);
  logic                 en_a;
  logic                 we_a;
  logic [ADDR_SIZE-1:0] addr_a;
  logic [DATA_SIZE-1:0] dout_a;
  logic                 en_b;
  logic                 we_b;
  logic [ADDR_SIZE-1:0] addr_b;
  logic [DATA_SIZE-1:0] din_b;

  modport master (
    output en_a, we_a, addr_a,
    input  dout_a,
    output en_b, we_b, addr_b, din_b
  );

  modport slave (
    input  en_a, we_a, addr_a,
    output dout_a,
    input  en_b, we_b, addr_b, din_b
  );
endinterface

// File: rtl/dpr_copy_engine.sv
// Copies len words from src to dst inside a dual-port RAM, one word per cycle,
// overlapping the read of word i with the write of word i-1.
module dpr_copy_engine #(
  parameter int ADDR_SIZE = 8,
  parameter int DATA_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [ADDR_SIZE-1:0] src_addr,
  input  logic [ADDR_SIZE-1:0] dst_addr,
  input  logic [ADDR_SIZE:0]   len,
  output logic                 busy,
  output logic                 done,
  output logic [ADDR_SIZE:0]   count,
  output logic [1:0]           dbg_state,
  dpr_copy_engine_if.master    ram
);

  // Handshake: start is a request sampled only in IDLE (ignored otherwise, never
  // queued); done is a one-cycle completion pulse; abort is sampled only in RUN.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t               state;
  logic [ADDR_SIZE:0]   rd_left;
  logic [ADDR_SIZE-1:0] wr_addr;
  logic                 en_a_r;
  logic                 en_b_r;
  logic [ADDR_SIZE-1:0] addr_a_r;
  logic [ADDR_SIZE-1:0] addr_b_r;

  assign dbg_state  = state;
  assign ram.en_a   = en_a_r;
  assign ram.we_a   = 1'b0;
  assign ram.addr_a = addr_a_r;
  assign ram.en_b   = en_b_r;
  assign ram.we_b   = en_b_r;
  assign ram.addr_b = addr_b_r;
  // Read data arrives one cycle after the read and goes straight to the write port.
  assign ram.din_b  = ram.dout_a;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      count    <= '0;
      rd_left  <= '0;
      wr_addr  <= '0;
      en_a_r   <= 1'b0;
      en_b_r   <= 1'b0;
      addr_a_r <= '0;
      addr_b_r <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            count    <= '0;
            wr_addr  <= dst_addr;
            addr_a_r <= src_addr;
            if (len != '0) begin
              state   <= RUN;
              busy    <= 1'b1;
              en_a_r  <= 1'b1;
              rd_left <= len - 1'b1;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        RUN: begin
          // Every RUN cycle issues a read, so the next cycle always writes.
          en_b_r   <= 1'b1;
          addr_b_r <= wr_addr;
          wr_addr  <= wr_addr + 1'b1;
          if (en_b_r) count <= count + 1'b1;
          if (abort || rd_left == '0) begin
            en_a_r <= 1'b0;
            state  <= DRAIN;
          end else begin
            addr_a_r <= addr_a_r + 1'b1;
            rd_left  <= rd_left - 1'b1;
          end
        end
        DRAIN: begin
          en_b_r <= 1'b0;
          busy   <= 1'b0;
          done   <= 1'b1;
          count  <= count + 1'b1;
          state  <= DONE;
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dpr_copy_engine.sv
// Bench for dpr_copy_engine: a read-first dual-port RAM model, a vector table of
// copies, randomized copies, and hand-written reset/abort sequences.
module tb_dpr_copy_engine;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       abort;
  logic [7:0] src_addr;
  logic [7:0] dst_addr;
  logic [8:0] len;
  logic       busy;
  logic       done;
  logic [8:0] count;
  logic [1:0] dbg_state;

  int n_cmp = 0;
  int n_bad = 0;

  dpr_copy_engine_if #(.ADDR_SIZE(8), .DATA_SIZE(8)) ram ();

  dpr_copy_engine #(.ADDR_SIZE(8), .DATA_SIZE(8)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .src_addr(src_addr), .dst_addr(dst_addr), .len(len),
    .busy(busy), .done(done), .count(count), .dbg_state(dbg_state),
    .ram(ram)
  );

  always #5 clk = ~clk;

  // RAM model: registered read, read-first on a same-address collision.
  logic [7:0] mem [256];
  logic       bd_we = 1'b0;
  logic [7:0] bd_addr, bd_data;

  always @(posedge clk) begin
    if (ram.en_a && !ram.we_a) ram.dout_a <= mem[ram.addr_a];
    if (ram.en_b && ram.we_b) mem[ram.addr_b] <= ram.din_b;
    if (bd_we) mem[bd_addr] <= bd_data;
  end

  typedef struct {
    string      name;
    logic [7:0] src;
    logic [7:0] dst;
    logic [8:0] n;
    int         abort_at;
    int         restart_at;
    logic [8:0] exp_count;
    int         exp_done;
  } vec_t;

  vec_t vecs[$];
  logic [7:0] exp_q[$];
  logic [7:0] ref_mem [256];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
    end
  endtask

  task automatic poke(input logic [7:0] a, input logic [7:0] d);
    bd_we = 1'b1; bd_addr = a; bd_data = d;
    @(negedge clk);
    bd_we = 1'b0;
  endtask

  // Called at a negedge with the engine idle. Cycle c counts from the edge that accepts start.
  task automatic run_copy(input vec_t v);
    int r, done_c, last, seen_done, bad_words;
    logic [7:0] w, a;
    r = (v.n == 0) ? 0 : ((v.abort_at > 0 && v.abort_at < int'(v.n)) ? v.abort_at : int'(v.n));
    done_c = (v.n == 0) ? 1 : r + 2;
    last = done_c + 1;
    seen_done = 0;
    exp_q.delete();
    ref_mem = mem;
    src_addr = v.src; dst_addr = v.dst; len = v.n; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    for (int c = 1; c <= last; c++) begin
      start = (c == v.restart_at);
      abort = (c == v.abort_at);
      if (start) begin
        src_addr = v.src ^ 8'h55; dst_addr = v.dst ^ 8'haa; len = 9'd3;
      end
      check($sformatf("%s busy c%0d", v.name, c), busy, (v.n > 0 && c <= r + 1));
      check($sformatf("%s done c%0d", v.name, c), done, (c == done_c));
      check($sformatf("%s en_a c%0d", v.name, c), ram.en_a, (v.n > 0 && c <= r));
      check($sformatf("%s en_b c%0d", v.name, c), ram.en_b, (v.n > 0 && c >= 2 && c <= r + 1));
      check($sformatf("%s we_b c%0d", v.name, c), ram.we_b, (v.n > 0 && c >= 2 && c <= r + 1));
      check($sformatf("%s we_a c%0d", v.name, c), ram.we_a, 0);
      if (done === 1'b1 && seen_done == 0) seen_done = c;
      w = 8'h00;
      if (v.n > 0 && c >= 2 && c <= r + 1) begin
        a = v.dst + 8'(c - 2);
        w = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        check($sformatf("%s addr_b c%0d", v.name, c), ram.addr_b, a);
        check($sformatf("%s din_b c%0d", v.name, c), ram.din_b, w);
      end
      if (v.n > 0 && c <= r) begin
        a = v.src + 8'(c - 1);
        check($sformatf("%s addr_a c%0d", v.name, c), ram.addr_a, a);
        exp_q.push_back(ref_mem[a]);
      end
      if (v.n > 0 && c >= 2 && c <= r + 1) ref_mem[v.dst + 8'(c - 2)] = w;
      if (c >= done_c) check($sformatf("%s count c%0d", v.name, c), count, v.exp_count);
      if (c < last) @(negedge clk);
    end
    start = 1'b0; abort = 1'b0;
    check($sformatf("%s done cycle", v.name), seen_done, v.exp_done);
    bad_words = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) bad_words++;
    check($sformatf("%s memory words differing", v.name), bad_words, 0);
  endtask

  initial begin
    int writes;
    vec_t rv;
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    src_addr = '0; dst_addr = '0; len = '0;
    @(negedge clk);
    for (int i = 0; i < 256; i++) poke(8'(i), 8'($urandom_range(0, 255)));
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset count", count, 0);
    check("reset en_a", ram.en_a, 0);
    check("reset en_b", ram.en_b, 0);
    check("reset we_b", ram.we_b, 0);
    check("reset state", dbg_state, 0);
    rst = 1'b0;
    poke(8'h10, 8'ha1); poke(8'h11, 8'hb2); poke(8'h12, 8'hc3); poke(8'h13, 8'hd4);

    vecs.push_back('{"basic",      8'h10, 8'h80, 9'd4,   0, 0, 9'd4,   6});
    vecs.push_back('{"zero_len",   8'h20, 8'h30, 9'd0,   0, 0, 9'd0,   1});
    vecs.push_back('{"wrap",       8'hfe, 8'h01, 9'd4,   0, 0, 9'd4,   6});
    vecs.push_back('{"abort3",     8'h40, 8'h90, 9'd8,   3, 0, 9'd3,   5});
    vecs.push_back('{"abort1",     8'h70, 8'hc0, 9'd5,   1, 0, 9'd1,   3});
    vecs.push_back('{"abort_drain",8'h78, 8'hc8, 9'd3,   4, 0, 9'd3,   5});
    vecs.push_back('{"start_busy", 8'h50, 8'ha0, 9'd8,   0, 3, 9'd8,  10});
    vecs.push_back('{"start_done", 8'h60, 8'hb0, 9'd2,   0, 4, 9'd2,   4});
    vecs.push_back('{"overlap",    8'h30, 8'h31, 9'd6,   0, 0, 9'd6,   8});
    vecs.push_back('{"full",       8'h00, 8'h00, 9'd256, 0, 0, 9'd256, 258});
    foreach (vecs[k]) run_copy(vecs[k]);

    // Basic copy destination must hold the preloaded words.
    check("basic dst 0x80", mem[8'h80], 8'ha1);
    check("basic dst 0x83", mem[8'h83], 8'hd4);

    for (int k = 0; k < 25; k++) begin
      int r;
      rv.name = $sformatf("rand%0d", k);
      rv.src = 8'($urandom_range(0, 255));
      rv.dst = 8'($urandom_range(0, 255));
      rv.n = ($urandom_range(0, 4) == 0) ? 9'($urandom_range(0, 1)) : 9'($urandom_range(2, 40));
      rv.abort_at = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, int'(rv.n) + 2)) : 0;
      rv.restart_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, int'(rv.n) + 2)) : 0;
      r = (rv.n == 0) ? 0 : ((rv.abort_at > 0 && rv.abort_at < int'(rv.n)) ? rv.abort_at : int'(rv.n));
      rv.exp_count = 9'(r);
      rv.exp_done = (rv.n == 0) ? 1 : r + 2;
      if (rv.n == 0) rv.restart_at = 0;
      run_copy(rv);
    end

    // Reset during cycle 3 of an 8-word copy: only the cycle 2 and 3 writes happen.
    poke(8'he0, 8'h00); poke(8'he1, 8'h00); poke(8'he2, 8'h5a);
    poke(8'h10, 8'h11); poke(8'h11, 8'h22);
    src_addr = 8'h10; dst_addr = 8'he0; len = 9'd8; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    writes = 0;
    for (int c = 1; c <= 3; c++) begin
      if (ram.en_b === 1'b1 && ram.we_b === 1'b1) writes++;
      if (c == 3) rst = 1'b1;
      @(negedge clk);
    end
    rst = 1'b0;
    check("rst_mid busy", busy, 0);
    check("rst_mid done", done, 0);
    check("rst_mid count", count, 0);
    check("rst_mid en_a", ram.en_a, 0);
    check("rst_mid en_b", ram.en_b, 0);
    check("rst_mid state", dbg_state, 0);
    check("rst_mid writes", writes, 2);
    @(negedge clk);
    check("rst_mid mem e0", mem[8'he0], 8'h11);
    check("rst_mid mem e1", mem[8'he1], 8'h22);
    check("rst_mid mem e2", mem[8'he2], 8'h5a);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
